// File: rtl/ccff_pkg.sv
// ccff_pkg: shared FSM states, CRC-16-CCITT constants and bit-serial CRC step
package ccff_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/ccff_crc16.sv
// ccff_crc16: bit-serial CRC-16-CCITT register with synchronous clear
module ccff_crc16
    import ccff_pkg::*;
(
    input  logic        prog_clk,
    input  logic        prog_reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    always_ff @(posedge prog_clk or negedge prog_reset_n)
        if (!prog_reset_n) crc <= CRC_INIT;
        else if (clr) crc <= CRC_INIT;
        else if (en) crc <= crc16_bit(crc, din);
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream words MSB-first into a config chain, with optional CRC verify pass
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              pass
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BUF_W = $clog2(WORD_W + 1);
    state_t             state, state_nx;
    logic               first, ver_q, pass_q, last_shift, go;
    logic [WORD_W-1:0]  buf_q;
    logic [BUF_W-1:0]   buf_cnt;
    logic [CNT_W-1:0]   req_cnt, sh_cnt;
    logic [15:0]        crc_wr, crc_rb;
    int                 take;
    always_ff @(posedge prog_clk or negedge prog_reset_n)
        if (!prog_reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        go         = state == IDLE && start;
        last_shift = shift_en && sh_cnt == CNT_W'(CHAIN_LEN - 1);
        state_nx   = state == IDLE   ? (start ? LOAD : IDLE) :
                     state == LOAD   ? (last_shift ? (ver_q ? VERIFY : DONE) : LOAD) :
                     state == VERIFY ? (last_shift ? DONE : VERIFY) : IDLE;
        take       = CHAIN_LEN - int'(req_cnt) > WORD_W ? WORD_W : CHAIN_LEN - int'(req_cnt);
    end
    always_comb begin
        busy      = state == LOAD || state == VERIFY;
        shift_en  = state == LOAD ? buf_cnt != '0 : state == VERIFY;
        ccff_head = state == LOAD ? (buf_cnt != '0 && buf_q[WORD_W-1]) : (state == VERIFY && ccff_tail);
        // one dead cycle after start; a word may land while its predecessor's last bit leaves
        in_ready  = state == LOAD && !first && int'(req_cnt) < CHAIN_LEN && buf_cnt <= BUF_W'(1);
        done      = state == DONE;
        pass      = state == DONE ? (!ver_q || crc_rb == crc_wr) : pass_q;
    end
    always_ff @(posedge prog_clk or negedge prog_reset_n)
        if (!prog_reset_n) begin
            first   <= 1'b0;
            ver_q   <= 1'b0;
            pass_q  <= 1'b0;
            buf_q   <= '0;
            buf_cnt <= '0;
            req_cnt <= '0;
            sh_cnt  <= '0;
        end else begin
            first <= go;
            if (go) begin
                ver_q   <= verify_en;
                pass_q  <= 1'b0;
                buf_cnt <= '0;
                req_cnt <= '0;
                sh_cnt  <= '0;
            end else begin
                if (in_valid && in_ready) begin
                    buf_q   <= in_data;
                    buf_cnt <= BUF_W'(take);
                    req_cnt <= req_cnt + CNT_W'(take);
                end else if (state == LOAD && shift_en) begin
                    buf_q   <= buf_q << 1;
                    buf_cnt <= buf_cnt - BUF_W'(1);
                end
                sh_cnt <= last_shift ? '0 : shift_en ? sh_cnt + CNT_W'(1) : sh_cnt;
                if (state == DONE) pass_q <= pass;
            end
        end
    ccff_crc16 u_crc_wr (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .clr(go),
        .en(state == LOAD && shift_en), .din(ccff_head), .crc(crc_wr)
    );
    ccff_crc16 u_crc_rb (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .clr(go),
        .en(state == VERIFY), .din(ccff_tail), .crc(crc_rb)
    );
endmodule
